// File: rtl/sar_scan_sequencer_if.sv
// Result port of the SAR scan sequencer.
// Channel-tagged conversion results on a valid/ready handshake.
interface sar_scan_sequencer_if #(
   parameter int WIDTH = 6,
   parameter int CH_W  = 2
);
   logic             res_valid_o;
   logic             res_ready_i;
   logic [CH_W-1:0]  res_ch_o;
   logic [WIDTH-1:0] res_data_o;

   modport master (
      output res_valid_o,
      output res_ch_o,
      output res_data_o,
      input  res_ready_i
   );

   modport slave (
      input  res_valid_o,
      input  res_ch_o,
      input  res_data_o,
      output res_ready_i
   );
endinterface

// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan controller for the SAR conversion FSM.
// Settles the mux, pulses SOC, waits for EOC and hands off tagged results.
module sar_scan_sequencer #(
   parameter int WIDTH    = 6,
   parameter int NCH      = 4,
   parameter int CH_W     = 2,
   parameter int SETTLE   = 2,
   parameter int TIMEOUT  = 63,
   parameter int PERIOD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 start_i,
   input  logic                 cont_i,
   input  logic [NCH-1:0]       ch_mask_i,
   input  logic [PERIOD_W-1:0]  period_i,
   output logic [CH_W-1:0]      ch_sel_o,
   output logic                 soc_o,
   input  logic                 eoc_i,
   input  logic [WIDTH-1:0]     data_i,
   sar_scan_sequencer_if.master res,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 timeout_o
);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int ST_W  = $clog2(SETTLE + 1);
   localparam int A_W   = (TO_W > ST_W) ? TO_W : ST_W;
   localparam int CNT_W = (A_W > PERIOD_W) ? A_W : PERIOD_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_SOC    = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_PUSH   = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_inc;
   logic [NCH-1:0]   mask_q;
   logic [CH_W:0]    first_in;
   logic [CH_W:0]    first_q;
   logic [CH_W:0]    nxt;
   logic [2:0]       adv_state;
   logic [CH_W-1:0]  adv_ch;
   logic             adv_done;

   // Lowest set bit at or above lo; MSB of the result flags a hit.
   function automatic logic [CH_W:0] find_from(
      input logic [NCH-1:0] m,
      input int             lo
   );
      find_from = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (m[i] && i >= lo)
            find_from = {1'b1, CH_W'(i)};
   endfunction

   assign cnt_inc  = {1'b0, cnt} + (CNT_W + 1)'(1);
   assign first_in = find_from(ch_mask_i, 0);
   assign first_q  = find_from(mask_q, 0);
   assign nxt      = find_from(mask_q, int'(ch_sel_o) + 1);
   assign soc_o    = (state == S_SOC);
   assign busy_o   = (state != S_IDLE);

   // Where a finished channel goes: next channel, next scan, gap or idle.
   always_comb begin
      adv_state = S_IDLE;
      adv_ch    = ch_sel_o;
      adv_done  = 1'b0;
      if (nxt[CH_W]) begin
         adv_state = S_SETTLE;
         adv_ch    = nxt[CH_W-1:0];
      end else begin
         adv_done = 1'b1;
         if (cont_i && en_i) begin
            if (period_i != '0) begin
               adv_state = S_GAP;
            end else begin
               adv_state = S_SETTLE;
               adv_ch    = first_q[CH_W-1:0];
            end
         end
      end
   end

   // Scan FSM, channel/result registers and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         mask_q          <= '0;
         ch_sel_o        <= '0;
         done_o          <= 1'b0;
         timeout_o       <= 1'b0;
         res.res_valid_o <= 1'b0;
         res.res_ch_o    <= '0;
         res.res_data_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i && en_i && (ch_mask_i != '0)) begin
                  mask_q    <= ch_mask_i;
                  timeout_o <= 1'b0;
                  ch_sel_o  <= first_in[CH_W-1:0];
                  cnt       <= '0;
                  state     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (!en_i) begin
                  state <= S_IDLE;
               end else if (cnt == CNT_W'(SETTLE - 1)) begin
                  cnt   <= '0;
                  state <= S_SOC;
               end else begin
                  cnt <= cnt_inc[CNT_W-1:0];
               end
            end
            S_SOC: begin
               cnt   <= '0;
               state <= en_i ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
               if (!en_i) begin
                  state <= S_IDLE;
               end else if (eoc_i && cnt != '0) begin
                  res.res_valid_o <= 1'b1;
                  res.res_ch_o    <= ch_sel_o;
                  res.res_data_o  <= data_i;
                  state           <= S_PUSH;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  timeout_o <= 1'b1;
                  cnt       <= '0;
                  state     <= adv_state;
                  ch_sel_o  <= adv_ch;
                  done_o    <= adv_done;
               end else begin
                  cnt <= cnt_inc[CNT_W-1:0];
               end
            end
            S_PUSH: begin
               if (res.res_ready_i) begin
                  res.res_valid_o <= 1'b0;
                  cnt             <= '0;
                  if (!en_i) begin
                     state <= S_IDLE;
                  end else begin
                     state    <= adv_state;
                     ch_sel_o <= adv_ch;
                     done_o   <= adv_done;
                  end
               end
            end
            S_GAP: begin
               if (!en_i) begin
                  state <= S_IDLE;
               end else if (cnt_inc >= (CNT_W + 1)'(period_i)) begin
                  mask_q <= ch_mask_i;
                  cnt    <= '0;
                  if (ch_mask_i != '0) begin
                     ch_sel_o <= first_in[CH_W-1:0];
                     state    <= S_SETTLE;
                  end else begin
                     done_o <= 1'b1;
                     state  <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt_inc[CNT_W-1:0];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: SAR response model,
// result scoreboard, vector table and corner-case sequences.
module tb_sar_scan_sequencer;
   localparam int WIDTH    = 6;
   localparam int NCH      = 4;
   localparam int CH_W     = 2;
   localparam int SETTLE   = 2;
   localparam int TIMEOUT  = 63;
   localparam int PERIOD_W = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                en = 1'b0;
   logic                start = 1'b0;
   logic                cont = 1'b0;
   logic [NCH-1:0]      mask = '0;
   logic [PERIOD_W-1:0] period = '0;
   logic [CH_W-1:0]     ch_sel;
   logic                soc;
   logic                eoc = 1'b0;
   logic [WIDTH-1:0]    data = '0;
   logic                busy;
   logic                done;
   logic                tout;

   sar_scan_sequencer_if #(.WIDTH(WIDTH), .CH_W(CH_W)) res ();

   sar_scan_sequencer #(
      .WIDTH(WIDTH), .NCH(NCH), .CH_W(CH_W),
      .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .PERIOD_W(PERIOD_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .start_i(start),
      .cont_i(cont), .ch_mask_i(mask), .period_i(period),
      .ch_sel_o(ch_sel), .soc_o(soc), .eoc_i(eoc), .data_i(data),
      .res(res), .busy_o(busy), .done_o(done), .timeout_o(tout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH_W-1:0]  ch;
      logic [WIDTH-1:0] d;
   } res_t;

   typedef struct {
      logic [NCH-1:0] mask;
      int             delay;
      logic [NCH-1:0] skip;
      int             stall;
      int             exp_res;
      int             exp_done;
      int             exp_to;
   } vec_t;

   int checks = 0;
   int errors = 0;
   res_t sb[$];
   vec_t vt[6];

   int m_cnt = 0;
   int delay = 8;
   int tag = 0;
   int stall = 0;
   logic [NCH-1:0] skip = '0;
   logic [CH_W-1:0] m_ch = '0;

   int cyc = 0;
   int done_cnt = 0;
   int res_cnt = 0;
   int soc_cnt = 0;
   int last_soc = 0;
   int to_lat = 0;
   int wait_cyc = 0;
   int soc_t[$];
   logic prev_soc = 1'b0;
   logic prev_to = 1'b0;
   res_t snap;
   res_t e;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] fdata(input int ch, input int t);
      return WIDTH'(ch * 11 + 5 + t * 7);
   endfunction

   // SAR model: answers delay cycles after SOC unless the channel is skipped.
   always @(negedge clk) begin
      eoc = 1'b0;
      data = WIDTH'($urandom);
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            eoc = 1'b1;
            data = fdata(int'(m_ch), tag);
         end
      end
      if (soc) begin
         m_ch = ch_sel;
         m_cnt = skip[ch_sel] ? 0 : delay;
      end
   end

   // Output monitor, consumer with backpressure, scoreboard pop.
   always @(negedge clk) begin
      cyc++;
      if (soc) begin
         chk("soc_width", prev_soc, 0);
         soc_cnt++;
         last_soc = cyc;
         soc_t.push_back(cyc);
      end
      if (tout && !prev_to) to_lat = cyc - last_soc;
      if (done) done_cnt++;
      prev_soc = soc;
      prev_to = tout;
      if (res.res_valid_o) begin
         if (!res.res_ready_i) begin
            if (wait_cyc == 0) begin
               snap.ch = res.res_ch_o;
               snap.d = res.res_data_o;
            end else begin
               chk("hold_ch", res.res_ch_o, snap.ch);
               chk("hold_data", res.res_data_o, snap.d);
            end
            chk("push_soc", soc, 0);
            wait_cyc++;
            if (wait_cyc >= stall) res.res_ready_i = 1'b1;
         end
         if (res.res_ready_i) begin
            res_cnt++;
            wait_cyc = 0;
            chk("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("res_ch", res.res_ch_o, e.ch);
               chk("res_data", res.res_data_o, e.d);
            end
         end
      end else begin
         wait_cyc = 0;
         res.res_ready_i = (stall == 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks %0d", checks);
      $fatal(1);
   end

   task automatic do_start(input logic [NCH-1:0] m, input logic c);
      @(posedge clk);
      #1;
      mask = m;
      cont = c;
      en = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < lim);
      chk(nm, busy, 0);
      @(negedge clk);
   endtask

   task automatic wait_soc(input string nm, input int lim, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!soc && k < lim);
      chk(nm, soc, 1);
   endtask

   task automatic wait_valid(input string nm, input int lim);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!res.res_valid_o && k < lim);
      chk(nm, res.res_valid_o, 1);
   endtask

   task automatic run_vec(input int i);
      int n0r, n0d, k, lo;
      delay = vt[i].delay;
      skip = vt[i].skip;
      stall = vt[i].stall;
      tag = i;
      to_lat = 0;
      lo = 0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (vt[i].mask[c]) lo = c;
      end
      for (int c = 0; c < NCH; c++) begin
         if (vt[i].mask[c] && !vt[i].skip[c] && vt[i].delay >= 2)
            sb.push_back('{CH_W'(c), fdata(c, i)});
      end
      n0r = res_cnt;
      n0d = done_cnt;
      do_start(vt[i].mask, 1'b0);
      chk("timeout_clr", tout, 0);
      chk("first_ch", ch_sel, lo);
      wait_soc("soc_seen", 20, k);
      chk("soc_lat", k, SETTLE + 1);
      wait_idle("vec_idle", 3000);
      chk("vec_res", res_cnt - n0r, vt[i].exp_res);
      chk("vec_done", done_cnt - n0d, vt[i].exp_done);
      chk("vec_to", tout, vt[i].exp_to);
      chk("vec_sb", sb.size(), 0);
      if (vt[i].exp_to != 0) chk("to_lat", to_lat, TIMEOUT + 1);
   endtask

   initial begin
      int n0r, n0d, n0s, k;
      vt[0] = '{4'b0101, 8, 4'b0000, 0, 2, 1, 0};
      vt[1] = '{4'b0110, 8, 4'b0000, 10, 2, 1, 0};
      vt[2] = '{4'b0011, 8, 4'b0010, 0, 1, 1, 1};
      vt[3] = '{4'b1111, 2, 4'b0000, 1, 4, 1, 0};
      vt[4] = '{4'b1001, 1, 4'b0000, 0, 0, 1, 1};
      vt[5] = '{4'b1000, 5, 4'b0000, 3, 1, 1, 0};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_soc", soc, 0);
      chk("rst_valid", res.res_valid_o, 0);
      chk("rst_done", done, 0);
      chk("rst_to", tout, 0);
      chk("rst_ch", ch_sel, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", busy, 0);

      for (int i = 0; i < 6; i++) run_vec(i);

      // zero mask start is ignored
      n0s = soc_cnt;
      do_start(4'b0000, 1'b0);
      repeat (4) @(negedge clk);
      chk("zmask_busy", busy, 0);
      chk("zmask_soc", soc_cnt - n0s, 0);

      // continuous single-channel scans with a 5-cycle gap
      delay = 8; skip = '0; stall = 0; tag = 10;
      period = 8'd5;
      for (int j = 0; j < 3; j++) sb.push_back('{CH_W'(3), fdata(3, 10)});
      soc_t.delete();
      n0r = res_cnt;
      n0d = done_cnt;
      do_start(4'b1000, 1'b1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (res_cnt < n0r + 3 && k < 300);
      chk("cont_res", res_cnt - n0r, 3);
      @(posedge clk);
      #1;
      en = 1'b0;
      wait_idle("cont_idle", 50);
      chk("cont_done", done_cnt - n0d, 3);
      chk("cont_socs", soc_t.size(), 3);
      if (soc_t.size() >= 3) begin
         chk("cont_gap1", soc_t[1] - soc_t[0], SETTLE + 1 + 8 + 1 + 5);
         chk("cont_gap2", soc_t[2] - soc_t[1], SETTLE + 1 + 8 + 1 + 5);
      end

      // relatched mask of zero ends continuous mode with a second done
      delay = 4; tag = 11; period = 8'd2;
      sb.push_back('{CH_W'(2), fdata(2, 11)});
      n0r = res_cnt;
      n0d = done_cnt;
      do_start(4'b0100, 1'b1);
      mask = '0;
      wait_idle("relatch_idle", 200);
      chk("relatch_res", res_cnt - n0r, 1);
      chk("relatch_done", done_cnt - n0d, 2);
      cont = 1'b0;
      period = '0;

      // enable dropped while waiting for EOC
      delay = 20; tag = 12;
      n0r = res_cnt;
      n0d = done_cnt;
      do_start(4'b0001, 1'b0);
      wait_soc("abw_soc", 20, k);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("abw_busy", busy, 0);
      repeat (25) @(negedge clk);
      chk("abw_res", res_cnt - n0r, 0);
      chk("abw_done", done_cnt - n0d, 0);

      // enable dropped during a stalled push: transfer completes, then idle
      delay = 4; tag = 13; stall = 6;
      sb.push_back('{CH_W'(0), fdata(0, 13)});
      n0r = res_cnt;
      n0d = done_cnt;
      n0s = soc_cnt;
      do_start(4'b0011, 1'b0);
      wait_valid("abp_valid", 40);
      en = 1'b0;
      wait_idle("abp_idle", 40);
      chk("abp_res", res_cnt - n0r, 1);
      chk("abp_done", done_cnt - n0d, 0);
      chk("abp_soc", soc_cnt - n0s, 1);
      chk("abp_sb", sb.size(), 0);
      stall = 0;

      // async reset in SETTLE
      tag = 14;
      do_start(4'b0100, 1'b0);
      chk("rs_pre_ch", ch_sel, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_busy", busy, 0);
      chk("rs_ch", ch_sel, 0);
      chk("rs_soc", soc, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // async reset while a result is held
      delay = 3; tag = 15; stall = 50;
      do_start(4'b0100, 1'b0);
      wait_valid("rp_valid", 40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rp_valid0", res.res_valid_o, 0);
      chk("rp_ch0", res.res_ch_o, 0);
      chk("rp_data0", res.res_data_o, 0);
      chk("rp_sel0", ch_sel, 0);
      chk("rp_busy0", busy, 0);
      stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rp_after", res.res_valid_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
